// File: rtl/vector_pkg.sv
// Shared types for the serial vector path (transmit serializer and receive buffer).
//   VEC_W      : vector width in bits (fixed; not overridden per instance)
//   vec_t      : one vector
//   bitcnt_t   : count of bits already shifted out of a vector
//   sh_state_t : shifter occupancy (empty / holding a vector)
package vector_pkg;
  localparam int VEC_W    = 8;
  localparam int BITCNT_W = 3;

  typedef logic [VEC_W-1:0]    vec_t;
  typedef logic [BITCNT_W-1:0] bitcnt_t;

  typedef enum logic {
    SH_EMPTY  = 1'b0,
    SH_LOADED = 1'b1
  } sh_state_t;

  localparam bitcnt_t LAST_BIT = bitcnt_t'(VEC_W - 1);
endpackage

// File: rtl/vector_serializer_if.sv
// Handshake bundle for vector_serializer.
//   vec_in/vec_valid/vec_ready : vector write handshake (producer -> serializer)
//   bit_out/bit_valid/bit_ready : serial bit handshake (serializer -> pin logic)
//   level                      : vectors buffered, excluding the one in the shifter
// Modports: slave = serializer side, master = environment side.
interface vector_serializer_if #(
  parameter int NB_VECTORS = 8
);
  import vector_pkg::*;

  localparam int LVL_W = $clog2(NB_VECTORS) + 1;

  vec_t             vec_in;
  logic             vec_valid;
  logic             vec_ready;
  logic             bit_out;
  logic             bit_valid;
  logic             bit_ready;
  logic [LVL_W-1:0] level;

  modport master (
    output vec_in, vec_valid, bit_ready,
    input  vec_ready, bit_out, bit_valid, level
  );

  modport slave (
    input  vec_in, vec_valid, bit_ready,
    output vec_ready, bit_out, bit_valid, level
  );
endinterface

// File: rtl/vector_fifo.sv
// Ring FIFO of vectors with occupancy counter.
//   clk, rst_n : clock, async active-low reset
//   push       : store wr_data (ignored while full)
//   pop        : advance read pointer (ignored while empty)
//   rd_data    : vector at the read pointer
//   full       : registered; also high during reset so nothing is accepted then
//   empty      : level == 0
//   level      : vectors held
// Full/empty come from level only; pointers wrap by natural overflow.
module vector_fifo
  import vector_pkg::*;
#(
  parameter  int NB_VECTORS = 8,
  localparam int PTR_W      = $clog2(NB_VECTORS),
  localparam int LVL_W      = PTR_W + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  vec_t             wr_data,
  output vec_t             rd_data,
  output logic             full,
  output logic             empty,
  output logic [LVL_W-1:0] level
);

  vec_t             mem [NB_VECTORS];
  logic [PTR_W-1:0] prod_q, cons_q;
  logic [LVL_W-1:0] level_q, level_nxt;
  logic             full_q;
  logic             do_push, do_pop;

  assign do_push = push && !full_q;
  assign do_pop  = pop && (level_q != '0);

  always_comb begin
    level_nxt = level_q;
    case ({do_push, do_pop})
      2'b10:   level_nxt = level_q + LVL_W'(1);
      2'b01:   level_nxt = level_q - LVL_W'(1);
      default: level_nxt = level_q;
    endcase
  end

  // full_q is precomputed from level_nxt so the write side never sees a
  // combinational path from the read side.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prod_q  <= '0;
      cons_q  <= '0;
      level_q <= '0;
      full_q  <= 1'b1;
    end else begin
      if (do_push) prod_q <= prod_q + PTR_W'(1);
      if (do_pop)  cons_q <= cons_q + PTR_W'(1);
      level_q <= level_nxt;
      full_q  <= (level_nxt == LVL_W'(NB_VECTORS));
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[prod_q] <= wr_data;
  end

  assign rd_data = mem[cons_q];
  assign full    = full_q;
  assign empty   = (level_q == '0);
  assign level   = level_q;

  level_in_range: assert property (@(posedge clk) disable iff (!rst_n)
    level_q <= LVL_W'(NB_VECTORS));

endmodule

// File: rtl/vector_serializer.sv
// Buffers 8-bit vectors and emits them MSB first over a bit handshake.
//   clk, rst_n : clock, async active-low reset
//   bus        : vector_serializer_if.slave (vector write side, serial bit side, level)
//
// state     | meaning
// SH_EMPTY  | shifter holds no vector; bit_valid low
// SH_LOADED | shifter holds a vector; bit_out is its next bit
module vector_serializer
  import vector_pkg::*;
#(
  parameter int NB_VECTORS = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  vector_serializer_if.slave   bus
);

  localparam int LVL_W = $clog2(NB_VECTORS) + 1;

  sh_state_t        state_q, state_nxt;
  vec_t             shift_q, shift_nxt;
  bitcnt_t          cnt_q, cnt_nxt;
  logic             consume, load, push;
  vec_t             fifo_data;
  logic             fifo_full, fifo_empty;
  logic [LVL_W-1:0] fifo_level;

  assign push    = bus.vec_valid && !fifo_full;
  assign consume = (state_q == SH_LOADED) && bus.bit_ready;
  // Reload on the edge that consumes the last bit so streams have no bubble.
  assign load    = !fifo_empty &&
                   ((state_q == SH_EMPTY) || (consume && (cnt_q == LAST_BIT)));

  vector_fifo #(
    .NB_VECTORS(NB_VECTORS)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push    (push),
    .pop     (load),
    .wr_data (bus.vec_in),
    .rd_data (fifo_data),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .level   (fifo_level)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= SH_EMPTY;
      shift_q <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_nxt;
      shift_q <= shift_nxt;
      cnt_q   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state_q;
    shift_nxt = shift_q;
    cnt_nxt   = cnt_q;
    if (load) begin
      state_nxt = SH_LOADED;
      shift_nxt = fifo_data;
      cnt_nxt   = '0;
    end else if (consume) begin
      shift_nxt = {shift_q[VEC_W-2:0], 1'b0};
      cnt_nxt   = cnt_q + bitcnt_t'(1);
      if (cnt_q == LAST_BIT) state_nxt = SH_EMPTY;
    end
  end

  assign bus.bit_out   = shift_q[VEC_W-1];
  assign bus.bit_valid = (state_q == SH_LOADED);
  assign bus.vec_ready = !fifo_full;
  assign bus.level     = fifo_level;

endmodule

// File: tb/tb_vector_serializer.sv
// Directed bench for vector_serializer: reset, single vector, back-to-back,
// backpressure, full/wrap and reset mid-stream. Inputs driven and outputs
// sampled on the falling edge.
module tb_vector_serializer;
  import vector_pkg::*;

  localparam int NB = 8;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   n_applied     = 0;
  int   n_miscompares = 0;

  vector_serializer_if #(.NB_VECTORS(NB)) vif ();

  vector_serializer #(.NB_VECTORS(NB)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (vif)
  );

  always #5 clk = ~clk;

  task automatic cyc();
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_applied++;
    if (got !== exp) begin
      n_miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic expect_bit(input logic b, input string tag);
    vif.bit_ready = 1'b1;
    chk({tag, "_bv"}, {31'd0, vif.bit_valid}, 32'd1);
    chk({tag, "_bo"}, {31'd0, vif.bit_out}, {31'd0, b});
    cyc();
  endtask

  task automatic expect_vec(input vec_t v, input string tag);
    for (int i = VEC_W - 1; i >= 0; i--) expect_bit(v[i], tag);
  endtask

  // Writes n (>=2) consecutive values with bit_ready low; the first one
  // moves into the shifter, so n-1 remain buffered.
  task automatic fill(input vec_t base, input int n);
    vif.bit_ready = 1'b0;
    for (int k = 0; k < n; k++) begin
      chk("fill_vr", {31'd0, vif.vec_ready}, 32'd1);
      vif.vec_in    = base + vec_t'(k);
      vif.vec_valid = 1'b1;
      cyc();
    end
    vif.vec_valid = 1'b0;
    chk("fill_lvl", 32'(vif.level), 32'(n - 1));
  endtask

  task automatic drain(input vec_t base, input int n);
    for (int k = 0; k < n; k++) expect_vec(base + vec_t'(k), "drain");
    chk("drain_idle", {31'd0, vif.bit_valid}, 32'd0);
    chk("drain_lvl", 32'(vif.level), 32'd0);
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vif.vec_in    = 8'h55;
    vif.vec_valid = 1'b1;
    vif.bit_ready = 1'b1;
    rst_n         = 1'b0;

    // reset held with vec_valid high
    repeat (3) begin
      cyc();
      chk("rst_vr",  {31'd0, vif.vec_ready}, 32'd0);
      chk("rst_bv",  {31'd0, vif.bit_valid}, 32'd0);
      chk("rst_bo",  {31'd0, vif.bit_out},   32'd0);
      chk("rst_lvl", 32'(vif.level),         32'd0);
    end
    rst_n         = 1'b1;
    vif.vec_valid = 1'b0;
    cyc();
    chk("rel_vr",  {31'd0, vif.vec_ready}, 32'd1);
    chk("rel_bv",  {31'd0, vif.bit_valid}, 32'd0);
    chk("rel_lvl", 32'(vif.level),         32'd0);

    // single vector, two-edge latency
    vif.vec_in    = 8'hA5;
    vif.vec_valid = 1'b1;
    cyc();
    vif.vec_valid = 1'b0;
    chk("lat_bv",  {31'd0, vif.bit_valid}, 32'd0);
    chk("lat_lvl", 32'(vif.level),         32'd1);
    cyc();
    expect_vec(8'hA5, "single");
    chk("single_end", {31'd0, vif.bit_valid}, 32'd0);

    // back-to-back, no bubble between vectors
    vif.vec_in    = 8'hFF;
    vif.vec_valid = 1'b1;
    cyc();
    vif.vec_in    = 8'h00;
    cyc();
    vif.vec_valid = 1'b0;
    expect_vec(8'hFF, "b2b_ff");
    expect_vec(8'h00, "b2b_00");
    chk("b2b_end", {31'd0, vif.bit_valid}, 32'd0);

    // backpressure after 3 bits of 0x3C (0,0,1 sent; next is 1)
    vif.vec_in    = 8'h3C;
    vif.vec_valid = 1'b1;
    cyc();
    vif.vec_valid = 1'b0;
    cyc();
    expect_bit(1'b0, "bp_pre");
    expect_bit(1'b0, "bp_pre");
    expect_bit(1'b1, "bp_pre");
    vif.bit_ready = 1'b0;
    repeat (5) begin
      cyc();
      chk("bp_hold_bv", {31'd0, vif.bit_valid}, 32'd1);
      chk("bp_hold_bo", {31'd0, vif.bit_out},   32'd1);
    end
    expect_bit(1'b1, "bp_post");
    expect_bit(1'b1, "bp_post");
    expect_bit(1'b1, "bp_post");
    expect_bit(1'b0, "bp_post");
    expect_bit(1'b0, "bp_post");
    chk("bp_end", {31'd0, vif.bit_valid}, 32'd0);

    // fill to capacity, refused 10th write, then drain and refill across wrap
    fill(8'h01, 9);
    chk("full_vr",  {31'd0, vif.vec_ready}, 32'd0);
    chk("full_lvl", 32'(vif.level),         32'd8);
    vif.vec_in    = 8'h0A;
    vif.vec_valid = 1'b1;
    cyc();
    vif.vec_valid = 1'b0;
    chk("refuse_lvl", 32'(vif.level),         32'd8);
    chk("refuse_vr",  {31'd0, vif.vec_ready}, 32'd0);
    drain(8'h01, 9);
    fill(8'h11, 9);
    drain(8'h11, 9);
    fill(8'h21, 6);
    drain(8'h21, 6);

    // reset mid-stream: 3 bits of 0xC3 sent, 4 vectors queued
    fill(8'hC3, 5);
    expect_bit(1'b1, "mid_pre");
    expect_bit(1'b1, "mid_pre");
    expect_bit(1'b0, "mid_pre");
    rst_n = 1'b0;
    #1;
    chk("mid_rst_bv",  {31'd0, vif.bit_valid}, 32'd0);
    chk("mid_rst_bo",  {31'd0, vif.bit_out},   32'd0);
    chk("mid_rst_vr",  {31'd0, vif.vec_ready}, 32'd0);
    chk("mid_rst_lvl", 32'(vif.level),         32'd0);
    cyc();
    cyc();
    rst_n         = 1'b1;
    vif.bit_ready = 1'b1;
    repeat (20) begin
      cyc();
      chk("post_rst_bv", {31'd0, vif.bit_valid}, 32'd0);
    end
    chk("post_rst_lvl", 32'(vif.level), 32'd0);

    // still functional after the reset
    vif.vec_in    = 8'h96;
    vif.vec_valid = 1'b1;
    cyc();
    vif.vec_valid = 1'b0;
    cyc();
    expect_vec(8'h96, "after_rst");
    chk("after_rst_end", {31'd0, vif.bit_valid}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_applied, n_miscompares);
    $finish;
  end

endmodule

// File: doc/vector_serializer.md
Name: vector_serializer

Overview:
- Transmit-side counterpart of the bit-to-vector buffer: accepts 8-bit vectors over a valid/ready handshake and buffers up to NB_VECTORS of them in a ring FIFO.
- Emits the vectors one bit at a time, MSB first, over a bit_valid/bit_ready handshake.
- Sits between the vector-producing core and the serial output pin logic.
- Bit order is chosen so a shift-left receiver reconstructs each vector exactly.

Parameters:
NB_VECTORS, 8, ring FIFO depth in vectors; power of 2, >= 2
VEC_W, 8, vector width in bits; fixed by package constant, not overridden per instance

Ports:
clk  input  1  single clock; all state updates on rising edge
rst_n  input  1  asynchronous, active-low reset
vec_in  input  8  vector to transmit
vec_valid  input  1  vec_in holds a vector
vec_ready  output  1  FIFO can accept a vector this cycle
bit_out  output  1  current serial bit
bit_valid  output  1  bit_out is meaningful
bit_ready  input  1  downstream consumes bit_out this cycle
level  output  $clog2(NB_VECTORS)+1  vectors held in FIFO, excluding the vector in the shifter

Behaviour:
- Reset (rst_n low, asynchronous): clear FIFO pointers, level, shift register, bit counter and shifter-loaded flag.
  - Outputs: vec_ready=0 while rst_n is low, 1 from the first cycle after release; bit_valid=0, bit_out=0, level=0.
  - Reset mid-vector discards the partial vector and all buffered vectors. No further bits from them appear.
- Write side:
  - vec_ready = (level != NB_VECTORS), registered-state derived, with no combinational path from bit_ready.
  - A write occurs on an edge where vec_valid && vec_ready; vec_in is stored at the prod pointer, and prod increments mod NB_VECTORS.
  - No bypass: a write when full is refused even if a read occurs in the same cycle.
  - vec_in may change freely when no write occurs.
- Read side (shifter):
  - The shifter holds one 8-bit vector plus a 3-bit counter of bits sent. bit_out = shifter MSB, and bit_valid = loaded flag.
  - A bit is consumed on an edge where bit_valid && bit_ready: shift left by 1 and increment the counter.
  - bit_out and bit_valid hold stable while bit_ready=0.
  - Load: on an edge where the FIFO is non-empty and (shifter empty, or the 8th bit is being consumed), copy fifo[cons] into the shifter, reset the counter to 0, and increment cons.
  - Consuming the 8th bit with the FIFO empty clears the loaded flag, so bit_valid=0 next cycle.
- Latency: a vector written at edge E0 into an empty FIFO with an idle shifter loads at E1. bit_valid=1 with its MSB after E1, i.e. 2 edges from presentation.
- Throughput: back-to-back vectors stream with no bubble; bit 0 of vector k is followed directly by bit 7 of vector k+1.
- Simultaneous write and load in one cycle: level unchanged, both pointers advance.
- Capacity: NB_VECTORS in FIFO plus 1 in the shifter.
- Pointer width: $clog2(NB_VECTORS). Wrap-around is natural overflow. Full/empty are decided by level, never by pointer equality.
- level is updated as level + write - load, saturating impossible by construction. An implementation assertion checks 0 <= level <= NB_VECTORS.

Decomposition:
- Shared package vector_pkg: VEC_W=8, typedef vec_t (logic [VEC_W-1:0]), typedef bitcnt_t (logic [2:0]).
- The same package is imported by the receive-side buffer.
- Sub-module vector_fifo: ring storage, prod/cons pointers, level, and push/pop/full/empty. It is reused later by the receive side.
- The shifter and handshake logic stay in vector_serializer.

Test Plan:
- Reset: hold rst_n=0 for 3 cycles with vec_valid=1 -> vec_ready=0, bit_valid=0, level=0; after release vec_ready=1.
- Single vector: write 0xA5 with bit_ready=1 -> bit_valid rises 2 edges later; bits 1,0,1,0,0,1,0,1 on 8 consecutive cycles; then bit_valid=0.
- Back-to-back: write 0xFF then 0x00 on consecutive cycles, bit_ready=1 -> 16 contiguous valid bits, 8 ones then 8 zeros, no gap.
- Backpressure: mid-vector 0x3C, hold bit_ready=0 for 5 cycles -> bit_out and bit_valid unchanged; the stream resumes with the correct next bit.
- Full and wrap: bit_ready=0, write 9 vectors 0x01..0x09 -> 9 accepted, level=8, vec_ready=0, the 10th is refused. Then drain and refill twice -> output order 0x01..0x09 and correct data after pointer wrap.
- Reset mid-stream: assert rst_n low after 3 bits of 0xC3 with 4 vectors queued -> bit_valid=0 immediately; after release level=0 and no stale bits are emitted.
